// File: rtl/pt_enc_rep_if.sv
// Handshake and data bundle between the word assembler (master) and the
// tri-state encoder (slave).
interface pt_enc_rep_if #(
    parameter int NBITS = 12,
    parameter int RW    = 4
);
    logic                 ld;
    logic [2*NBITS-1:0]   ad;
    logic [RW-1:0]        rep;
    logic                 abort;
    logic                 q;
    logic                 busy;
    logic                 done;

    modport master (
        output ld, ad, rep, abort,
        input  q, busy, done
    );

    modport slave (
        input  ld, ad, rep, abort,
        output q, busy, done
    );
endinterface

// File: rtl/pt_enc_rep.sv
// PT2262-style tri-state encoder: NBITS code bits plus a sync bit per frame,
// repeated rep+1 times, with the tick rate divided down from clk.
module pt_enc_rep #(
    parameter int NBITS    = 12,
    parameter int TICK_DIV = 1,
    parameter int RW       = 4
) (
    input  logic         clk,
    input  logic         rst,
    pt_enc_rep_if.slave  bus
);
    localparam int DW = $clog2(TICK_DIV) + 1;
    localparam int IW = $clog2(NBITS) + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [IW-1:0] BIT_MSB   = IW'(NBITS - 1);
    localparam logic [IW-1:0] BIT_ONE   = IW'(1);
    localparam logic [RW:0]   FRAME_ONE = (RW+1)'(1);
    localparam logic [6:0]    BIT_LAST  = 7'd31;
    localparam logic [6:0]    SYNC_LAST = 7'd127;

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_SYNC} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [6:0]           phase_q, phase_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [RW:0]          frame_q, frame_d;
    logic [2*NBITS-1:0]   ad_q, ad_d;
    logic [RW-1:0]        rep_q, rep_d;
    logic                 q_q, q_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [1:0]           code_arr [NBITS];
    logic [1:0]           code_cur;
    logic [6:0]           phase_inc;

    for (genvar gi = 0; gi < NBITS; gi++) begin : g_code
        assign code_arr[gi] = ad_q[2*gi +: 2];
    end

    // Level of one tick inside a code bit; both halves of every pattern start high.
    function automatic logic bit_level(input logic [1:0] code, input logic [4:0] ph);
        case (code)
            2'b01:   bit_level = (ph[3:0] < 4'd12);
            2'b10:   bit_level = ph[4] ? (ph[3:0] < 4'd12) : (ph[3:0] < 4'd4);
            default: bit_level = (ph[3:0] < 4'd4);
        endcase
    endfunction

    always_comb begin
        code_cur = 2'b00;
        for (int i = 0; i < NBITS; i++) begin
            if (bit_q == IW'(i)) code_cur = code_arr[i];
        end
    end

    assign phase_inc = phase_q + 7'd1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        ad_d    = ad_q;
        rep_d   = rep_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                q_d = 1'b0;
                if (bus.ld && !bus.abort) begin
                    state_d = S_BIT;
                    ad_d    = bus.ad;
                    rep_d   = bus.rep;
                    div_d   = '0;
                    phase_d = '0;
                    bit_d   = BIT_MSB;
                    frame_d = '0;
                    q_d     = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    phase_d = '0;
                    bit_d   = '0;
                    frame_d = '0;
                    q_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (state_q == S_BIT) begin
                        if (phase_q != BIT_LAST) begin
                            phase_d = phase_inc;
                            q_d     = bit_level(code_cur, phase_inc[4:0]);
                        end else begin
                            phase_d = '0;
                            q_d     = 1'b1;
                            if (bit_q != '0) bit_d = bit_q - BIT_ONE;
                            else             state_d = S_SYNC;
                        end
                    end else if (phase_q != SYNC_LAST) begin
                        phase_d = phase_inc;
                        q_d     = (phase_inc < 7'd4);
                    end else if (frame_q == {1'b0, rep_q}) begin
                        state_d = S_IDLE;
                        phase_d = '0;
                        bit_d   = '0;
                        frame_d = '0;
                        q_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_BIT;
                        phase_d = '0;
                        bit_d   = BIT_MSB;
                        frame_d = frame_q + FRAME_ONE;
                        q_d     = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            ad_q    <= '0;
            rep_q   <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            ad_q    <= ad_d;
            rep_q   <= rep_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pt_enc_rep.sv
// Directed bench for pt_enc_rep: two instances (tick divider 1 and 3) share the
// stimulus and are checked every cycle against a waveform-queue model.
module tb_pt_enc_rep;
    localparam int NB  = 2;
    localparam int RWP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] ad = '0;
    logic [3:0] rep = '0;
    logic       abort = 1'b0;

    always #5 clk = ~clk;

    pt_enc_rep_if #(.NBITS(NB), .RW(RWP)) if1 ();
    pt_enc_rep_if #(.NBITS(NB), .RW(RWP)) if3 ();

    assign if1.ld = ld;  assign if1.ad = ad;  assign if1.rep = rep;  assign if1.abort = abort;
    assign if3.ld = ld;  assign if3.ad = ad;  assign if3.rep = rep;  assign if3.abort = abort;

    pt_enc_rep #(.NBITS(NB), .TICK_DIV(1), .RW(RWP)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    pt_enc_rep #(.NBITS(NB), .TICK_DIV(3), .RW(RWP)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int checks = 0;
    int errors = 0;
    int k = 0;

    bit   mq [2][$];
    bit   exp_q [2];
    bit   exp_busy [2];
    bit   exp_done [2];
    logic act_q [2];
    logic act_busy [2];
    logic act_done [2];
    int   tdiv [2] = '{1, 3};

    assign act_q[0] = if1.q;  assign act_busy[0] = if1.busy;  assign act_done[0] = if1.done;
    assign act_q[1] = if3.q;  assign act_busy[1] = if3.busy;  assign act_done[1] = if3.done;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_run(input int i, input bit lvl, input int n);
        repeat (n * tdiv[i]) mq[i].push_back(lvl);
    endtask

    // Whole transmission as a per-cycle level list, built from the run-length tables.
    task automatic build(input int i, input logic [3:0] a, input logic [3:0] r);
        logic [1:0] c;
        for (int f = 0; f <= int'(r); f++) begin
            for (int b = NB - 1; b >= 0; b--) begin
                c = a[2*b +: 2];
                case (c)
                    2'b01: begin push_run(i,1,12); push_run(i,0,4); push_run(i,1,12); push_run(i,0,4); end
                    2'b10: begin push_run(i,1,4); push_run(i,0,12); push_run(i,1,12); push_run(i,0,4); end
                    default: begin push_run(i,1,4); push_run(i,0,12); push_run(i,1,4); push_run(i,0,12); end
                endcase
            end
            push_run(i, 1, 4);
            push_run(i, 0, 124);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int i = 0; i < 2; i++) begin
                if (!rst) begin
                    mq[i].delete();
                    exp_done[i] = 1'b0;
                end else if (mq[i].size() != 0) begin
                    exp_done[i] = 1'b0;
                    if (abort) mq[i].delete();
                    else begin
                        void'(mq[i].pop_front());
                        if (mq[i].size() == 0) exp_done[i] = 1'b1;
                    end
                end else begin
                    exp_done[i] = 1'b0;
                    if (ld && !abort) build(i, ad, rep);
                end
                exp_busy[i] = (mq[i].size() != 0);
                exp_q[i]    = exp_busy[i] ? mq[i][0] : 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("model_q_dut%0d", i), act_q[i], exp_q[i]);
                    chk($sformatf("model_busy_dut%0d", i), act_busy[i], exp_busy[i]);
                    chk($sformatf("model_done_dut%0d", i), act_done[i], exp_done[i]);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic pulse_ld(input logic [3:0] a, input logic [3:0] r);
        @(negedge clk);
        ld = 1'b1; ad = a; rep = r;
        @(negedge clk);
        ld = 1'b0;
        k = 1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((if1.busy || if3.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_int("idle_within_budget", int'(n < 3000), 1);
    endtask

    initial begin
        int nd;
        repeat (3) @(negedge clk);
        chk("rst_q1", if1.q, 1'b0);     chk("rst_busy1", if1.busy, 1'b0);  chk("rst_done1", if1.done, 1'b0);
        chk("rst_q3", if3.q, 1'b0);     chk("rst_busy3", if3.busy, 1'b0);  chk("rst_done3", if3.done, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // "0" then "F", single frame
        pulse_ld(4'b0010, 4'd0);
        while (k <= 193) begin
            case (k)
                1:  chk("t1_q_c1", if1.q, 1'b1);
                4:  chk("t1_q_c4", if1.q, 1'b1);
                5:  chk("t1_q_c5", if1.q, 1'b0);
                16: chk("t1_q_c16", if1.q, 1'b0);
                17: chk("t1_q_c17", if1.q, 1'b1);
                21: chk("t1_q_c21", if1.q, 1'b0);
                33: chk("t1_q_c33", if1.q, 1'b1);
                37: chk("t1_q_c37", if1.q, 1'b0);
                49: chk("t1_q_c49", if1.q, 1'b1);
                60: chk("t1_q_c60", if1.q, 1'b1);
                61: chk("t1_q_c61", if1.q, 1'b0);
                65: chk("t1_q_c65", if1.q, 1'b1);
                69: chk("t1_q_c69", if1.q, 1'b0);
                192: begin chk("t1_busy_c192", if1.busy, 1'b1); chk("t1_done_c192", if1.done, 1'b0); end
                193: begin chk("t1_done_c193", if1.done, 1'b1); chk("t1_busy_c193", if1.busy, 1'b0); end
                default: ;
            endcase
            step();
        end
        wait_idle();

        // "1","1" at both tick rates
        pulse_ld(4'b0101, 4'd0);
        while (k <= 577) begin
            case (k)
                1:   chk("t2_q3_c1", if3.q, 1'b1);
                12:  chk("t2_q1_c12", if1.q, 1'b1);
                13:  chk("t2_q1_c13", if1.q, 1'b0);
                36:  chk("t2_q3_c36", if3.q, 1'b1);
                37:  chk("t2_q3_c37", if3.q, 1'b0);
                48:  chk("t2_q3_c48", if3.q, 1'b0);
                49:  chk("t2_q3_c49", if3.q, 1'b1);
                576: begin chk("t2_busy3_c576", if3.busy, 1'b1); chk("t2_done3_c576", if3.done, 1'b0); end
                577: begin chk("t2_done3_c577", if3.done, 1'b1); chk("t2_busy3_c577", if3.busy, 1'b0); end
                default: ;
            endcase
            step();
        end
        wait_idle();

        // three frames of reserved codes, with ignored ld pulses mid-run
        pulse_ld(4'b1111, 4'd2);
        nd = 0;
        while (k <= 600) begin
            if (if1.done) nd++;
            case (k)
                100: begin ld = 1'b1; ad = 4'b0110; rep = 4'd5; end
                101: ld = 1'b0;
                385: chk("t3_q1_c385", if1.q, 1'b1);
                389: chk("t3_q1_c389", if1.q, 1'b0);
                401: chk("t3_q1_c401", if1.q, 1'b1);
                405: chk("t3_q1_c405", if1.q, 1'b0);
                576: chk("t3_busy1_c576", if1.busy, 1'b1);
                577: chk("t3_done1_c577", if1.done, 1'b1);
                default: ;
            endcase
            step();
        end
        chk_int("t3_done_count", nd, 1);
        wait_idle();

        // abort mid-frame, then restart from the MSB
        pulse_ld(4'b0110, 4'd1);
        nd = 0;
        while (k <= 60) begin
            if (if1.done || if3.done) nd++;
            if (k == 40) abort = 1'b1;
            if (k == 41) begin
                chk("t4_q1_c41", if1.q, 1'b0);     chk("t4_busy1_c41", if1.busy, 1'b0);
                chk("t4_busy3_c41", if3.busy, 1'b0);
                abort = 1'b0;
            end
            step();
        end
        chk_int("t4_no_done", nd, 0);
        pulse_ld(4'b1000, 4'd0);
        while (k <= 21) begin
            if (k == 1)  chk("t4_restart_busy", if1.busy, 1'b1);
            if (k == 21) chk("t4_restart_msb_F", if1.q, 1'b1);
            step();
        end
        wait_idle();

        // ld held through done
        @(negedge clk);
        ld = 1'b1; ad = 4'b0001; rep = 4'd0;
        @(negedge clk);
        k = 1;
        while (k <= 194) begin
            if (k == 193) begin chk("t5_done_c193", if1.done, 1'b1); chk("t5_busy_c193", if1.busy, 1'b0); end
            if (k == 194) begin
                chk("t5_q_c194", if1.q, 1'b1); chk("t5_busy_c194", if1.busy, 1'b1);
                chk("t5_done_c194", if1.done, 1'b0);
                ld = 1'b0;
            end
            step();
        end
        wait_idle();

        // asynchronous reset mid-frame
        pulse_ld(4'b0101, 4'd0);
        while (k < 100) step();
        chk("t6_q3_pre", if3.q, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_q1_async", if1.q, 1'b0);    chk("t6_busy1_async", if1.busy, 1'b0);
        chk("t6_q3_async", if3.q, 1'b0);    chk("t6_busy3_async", if3.busy, 1'b0);
        chk("t6_done3_async", if3.done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_idle_q1", if1.q, 1'b0);
            chk("t6_idle_busy3", if3.busy, 1'b0);
        end
        pulse_ld(4'b0010, 4'd0);
        while (k <= 17) begin
            if (k == 1)  chk("t6_restart_q_c1", if1.q, 1'b1);
            if (k == 5)  chk("t6_restart_q_c5", if1.q, 1'b0);
            if (k == 17) chk("t6_restart_q_c17", if1.q, 1'b1);
            step();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
